// File: rtl/mux_arbiter4_if.sv
// Requester/downstream bus of the 4-way round-robin arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mux_arbiter4_if #(
  parameter int DATA_W = 8
);
  logic [3:0]        req;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] data3;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        grant;
  logic [1:0]        sel;

  modport slave (
    input  req, data0, data1, data2, data3, out_ready,
    output out_valid, out_data, grant, sel
  );

  modport master (
    output req, data0, data1, data2, data3, out_ready,
    input  out_valid, out_data, grant, sel
  );
endinterface

// File: rtl/mux_arbiter4.sv
// 4-way round-robin arbiter driving a shared 4:1 data mux.
// An owner keeps the grant for up to MAX_BEATS accepted beats or until it
// drops its request; every grant is followed by at least one idle cycle.
module mux_arbiter4 #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux_arbiter4_if.slave      bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BEATS - 1);

  state_t            r_state;
  logic [1:0]        r_owner;
  logic [1:0]        r_ptr;
  logic [3:0]        r_cnt;

  state_t            w_state_nx;
  logic [1:0]        w_owner_nx;
  logic [1:0]        w_ptr_nx;
  logic [3:0]        w_cnt_nx;
  logic [1:0]        w_pick;
  logic              w_accept;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;
  logic [3:0]        w_grant;
  logic [1:0]        w_sel;

  // Round-robin search: first requester at or after r_ptr (mod 4).
  // Iterating from the farthest offset down lets the nearest one win.
  always_comb begin
    w_pick = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[r_ptr + 2'(k)]) begin
        w_pick = r_ptr + 2'(k);
      end
    end
  end

  // Next-state and output decode from the registered owner.
  always_comb begin
    w_state_nx  = r_state;
    w_owner_nx  = r_owner;
    w_ptr_nx    = r_ptr;
    w_cnt_nx    = r_cnt;
    w_accept    = 1'b0;
    w_out_valid = 1'b0;
    w_out_data  = bus.data0;
    w_grant     = 4'b0000;
    w_sel       = 2'b00;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_state_nx = BUSY;
          w_owner_nx = w_pick;
          w_cnt_nx   = 4'd0;
        end
      end
      BUSY: begin
        w_grant     = 4'b0001 << r_owner;
        w_sel       = r_owner;
        w_out_valid = bus.req[r_owner];
        case (r_owner)
          2'd0:    w_out_data = bus.data0;
          2'd1:    w_out_data = bus.data1;
          2'd2:    w_out_data = bus.data2;
          default: w_out_data = bus.data3;
        endcase
        w_accept = w_out_valid && bus.out_ready;
        // Release on the last allowed beat or when the owner withdraws;
        // the pointer moves past the releasing owner only here.
        if ((w_accept && (r_cnt == LAST_BEAT)) || !bus.req[r_owner]) begin
          w_state_nx = IDLE;
          w_ptr_nx   = r_owner + 2'd1;
          w_cnt_nx   = 4'd0;
        end else if (w_accept) begin
          w_cnt_nx = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // Control registers; reset overrides every other transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.grant     = w_grant;
  assign bus.sel       = w_sel;

endmodule
